bit_serial_adder: RTL and testbench

//   Multi-cycle WIDTH-bit adder built around one 1-bit full-adder cell, reused once per clock.

---
 rtl/serial_arith_defs.sv | 14 +
 rtl/fa_cell.sv | 16 +
 rtl/bit_serial_adder.sv | 110 +++++++++++
 tb/tb_bit_serial_adder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_defs.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding
// and the supported operand width range.
package serial_arith_defs;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; the only arithmetic in the serial adder.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = x ^ y;
  assign s    = p ^ cin;
  assign cout = (x & y) | (p & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// WIDTH-bit adder that walks the operands LSB-first through a single
// full-adder cell, one bit per clock, then publishes {cout,sum}.
module bit_serial_adder
  import serial_arith_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;
  logic             accept;

  fa_cell u_fa (
    .x   (a_sh_q[0]),
    .y   (b_sh_q[0]),
    .cin (c_q),
    .s   (fa_s),
    .cout(fa_c)
  );

  // A new request is taken from IDLE or straight out of DONE, never mid-RUN.
  assign accept = start && (state_q != ST_RUN);

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    c_d      = c_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        c_d      = fa_c;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
          cout_d  = fa_c;
        end
      end
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d  = ST_RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          c_d      = cin;
          cnt_d    = '0;
          sum_sh_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      c_q      <= c_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder at WIDTH=8 and WIDTH=2 against
// a plain a+b+cin reference with a fixed WIDTH+1 cycle completion.
module tb_bit_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start2 = 1'b0, cin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  int errors = 0;
  int checks = 0;

  // Last result the model says each DUT should be holding.
  logic [8:0] exp_res8 = '0;
  logic [2:0] exp_res2 = '0;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  bit_serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'hC3; cin8 = 1'b1;
    start2 = 1'b1; a2 = 2'b11; b2 = 2'b01; cin2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({busy8, done8, sum8, cout8, busy2, done2, sum2, cout2} !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got busy=%b done=%b sum=%h cout=%b (w2 %b%b%h%b) want all 0",
                 i, busy8, done8, sum8, cout8, busy2, done2, sum2, cout2);
      end
    end
    start8 = 1'b0; start2 = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({busy8, done8, sum8, cout8, busy2, done2, sum2, cout2} !== '0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b done=%b sum=%h cout=%b want all 0",
               busy8, done8, sum8, cout8);
    end
    $display("reset: done");
  endtask

  task automatic test_basic();
    logic [7:0] va [3] = '{8'h0F, 8'hFF, 8'hFF};
    logic [7:0] vb [3] = '{8'h01, 8'h00, 8'hFF};
    logic       vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [8:0] exp;
    for (int k = 0; k < 3; k++) begin
      a8 = va[k]; b8 = vb[k]; cin8 = vc[k]; start8 = 1'b1;
      exp = {1'b0, va[k]} + {1'b0, vb[k]} + {8'b0, vc[k]};
      tick();
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0 || {cout8, sum8} !== exp_res8) begin
          errors++;
          $display("FAIL basic%0d_run cyc%0d: got busy=%b done=%b res=%h want busy=1 done=0 res=%h",
                   k, i, busy8, done8, {cout8, sum8}, exp_res8);
        end
        tick();
      end
      checks++;
      if (done8 !== 1'b1 || busy8 !== 1'b0 || {cout8, sum8} !== exp) begin
        errors++;
        $display("FAIL basic%0d_done: got done=%b busy=%b res=%h want done=1 busy=0 res=%h",
                 k, done8, busy8, {cout8, sum8}, exp);
      end
      exp_res8 = exp;
      tick();
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || {cout8, sum8} !== exp_res8) begin
        errors++;
        $display("FAIL basic%0d_after: got done=%b busy=%b res=%h want done=0 busy=0 res=%h",
                 k, done8, busy8, {cout8, sum8}, exp_res8);
      end
      $display("basic: %h + %h + %0d -> sum=%h cout=%b", va[k], vb[k], vc[k], sum8, cout8);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [3] = '{8'h12, 8'hA0, 8'h3C};
    logic [7:0] vb [3] = '{8'h34, 8'h60, 8'hC4};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] exp;
    start8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a8 = va[k]; b8 = vb[k]; cin8 = vc[k];
      exp = {1'b0, va[k]} + {1'b0, vb[k]} + {8'b0, vc[k]};
      tick();
      for (int i = 0; i < 8; i++) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0 || {cout8, sum8} !== exp_res8) begin
          errors++;
          $display("FAIL b2b%0d_run cyc%0d: got busy=%b done=%b res=%h want busy=1 done=0 res=%h",
                   k, i, busy8, done8, {cout8, sum8}, exp_res8);
        end
        tick();
      end
      checks++;
      if (done8 !== 1'b1 || {cout8, sum8} !== exp) begin
        errors++;
        $display("FAIL b2b%0d_done: got done=%b res=%h want done=1 res=%h",
                 k, done8, {cout8, sum8}, exp);
      end
      exp_res8 = exp;
      $display("b2b: %h + %h + %0d -> sum=%h cout=%b", va[k], vb[k], vc[k], sum8, cout8);
    end
    start8 = 1'b0;
    tick();
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got busy=%b done=%b want 0 0", busy8, done8);
    end
  endtask

  task automatic test_reset_mid_run();
    a8 = 8'h55; b8 = 8'hAA; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8} !== '0) begin
      errors++;
      $display("FAIL midrst_abort: got busy=%b done=%b sum=%h cout=%b want all 0",
               busy8, done8, sum8, cout8);
    end
    exp_res8 = '0;
    exp_res2 = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({busy8, done8, sum8, cout8} !== '0) begin
        errors++;
        $display("FAIL midrst_quiet cyc%0d: got busy=%b done=%b sum=%h cout=%b want all 0",
                 i, busy8, done8, sum8, cout8);
      end
    end
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (8) tick();
    checks++;
    if (done8 !== 1'b1 || {cout8, sum8} !== 9'h002) begin
      errors++;
      $display("FAIL midrst_next: got done=%b res=%h want done=1 res=002", done8, {cout8, sum8});
    end
    exp_res8 = 9'h002;
    $display("midrst: aborted 55+AA, then 01+01 -> sum=%h cout=%b", sum8, cout8);
    tick();
  endtask

  task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s);
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; cin8 = c; start8 = s;
    end else begin
      a2 = a[1:0]; b2 = b[1:0]; cin2 = c; start2 = s;
    end
  endtask

  function automatic logic [32:0] get_res(input int w);
    return (w == 8) ? {24'b0, cout8, sum8} : {30'b0, cout2, sum2};
  endfunction

  function automatic logic [1:0] get_flags(input int w);
    return (w == 8) ? {busy8, done8} : {busy2, done2};
  endfunction

  task automatic test_random(input int w);
    logic [32:0] exp, held;
    logic [31:0] ra, rb, mask;
    logic        rc;
    int          fails_before;
    fails_before = errors;
    mask = (32'd1 << w) - 32'd1;
    held = (w == 8) ? {24'b0, exp_res8} : {30'b0, exp_res2};
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(w, $urandom, $urandom, 1'($urandom), 1'b0);
        tick();
        checks++;
        if (get_flags(w) !== 2'b00 || get_res(w) !== held) begin
          errors++;
          $display("FAIL rand%0d_idle op%0d: got flags=%b res=%h want flags=00 res=%h",
                   w, n, get_flags(w), get_res(w), held);
        end
      end
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      exp = {1'b0, ra & mask} + {1'b0, rb & mask} + {32'b0, rc};
      drive(w, ra, rb, rc, 1'b1);
      tick();
      for (int i = 0; i < w; i++) begin
        drive(w, $urandom, $urandom, 1'($urandom), 1'($urandom));
        checks++;
        if (get_flags(w) !== 2'b10 || get_res(w) !== held) begin
          errors++;
          $display("FAIL rand%0d_run op%0d cyc%0d: got flags=%b res=%h want flags=10 res=%h",
                   w, n, i, get_flags(w), get_res(w), held);
        end
        tick();
      end
      checks++;
      if (get_flags(w) !== 2'b01 || get_res(w) !== exp) begin
        errors++;
        $display("FAIL rand%0d_done op%0d: a=%h b=%h cin=%b got flags=%b res=%h want flags=01 res=%h",
                 w, n, ra & mask, rb & mask, rc, get_flags(w), get_res(w), exp);
      end
      held = exp;
    end
    drive(w, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    if (w == 8) exp_res8 = held[8:0];
    else        exp_res2 = held[2:0];
    $display("random w=%0d: 1000 ops, %0d new errors", w, errors - fails_before);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid_run();
    test_random(8);
    test_random(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
